rs_issue_sched: RTL and testbench

Reservation-station controller for the Tomasulo add/mul units. Allocates decoded operations into a small station, captures operands from the common data bus (CDB), and issues one ready entry per cycle to the attached functional unit with a valid/ready handshake. One instance sits in front of each functional-unit class (add/branch/load-store, mul/div) and replaces direct writes into the station arrays from the decode stage.

---
 rtl/tomasulo_pkg.sv | 26 ++
 rtl/rs_select.sv | 39 +++
 rtl/rs_issue_sched.sv | 166 ++++++++++++++++
 tb/tb_rs_issue_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared opcodes, tag width and station entry layout
package tomasulo_pkg;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0010;
  localparam logic [3:0] FN_DIV = 4'b0011;
  localparam logic [3:0] FN_LD  = 4'b0100;
  localparam logic [3:0] FN_ST  = 4'b0101;
  localparam logic [3:0] FN_BEQ = 4'b0110;
  localparam logic [3:0] FN_BNE = 4'b0111;

  localparam int TAGW = 3;

  // Operand values live beside this struct so DW stays a per-instance parameter
  typedef struct packed {
    logic            busy;
    logic [3:0]      func;
    logic [TAGW-1:0] rob;
    logic            q1_busy;
    logic [TAGW-1:0] q1_tag;
    logic            q2_busy;
    logic [TAGW-1:0] q2_tag;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - picks one ready entry; RS_AGE_PRIORITY_EN selects oldest, else lowest index
module rs_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   ready,
`ifdef RS_AGE_PRIORITY_EN
  input  logic [N*N-1:0] older,
`endif
  output logic [N-1:0]   grant,
  output logic [IW-1:0]  idx,
  output logic           any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |ready;
`ifdef RS_AGE_PRIORITY_EN
    // older[j*N+i] set means entry j was allocated before entry i
    for (int i = 0; i < N; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (ready[j] && older[j*N+i]) blocked = 1'b1;
      end
      if (ready[i] && !blocked) grant[i] = 1'b1;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) grant = N'(1) << i;
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - reservation station: allocate, CDB wakeup, single issue per cycle
// Optional oldest-first selection with RS_AGE_PRIORITY_EN.
module rs_issue_sched #(
  parameter int ENTRIES = 4,
  parameter int DW      = 16,
  parameter int TAGW    = tomasulo_pkg::TAGW
) (
  input  logic                         clk2,
  input  logic                         rst_n,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [3:0]                   alloc_func,
  input  logic [TAGW-1:0]              alloc_rob,
  input  logic                         alloc_q1_busy,
  input  logic                         alloc_q2_busy,
  input  logic [TAGW-1:0]              alloc_q1_tag,
  input  logic [TAGW-1:0]              alloc_q2_tag,
  input  logic [DW-1:0]                alloc_v1,
  input  logic [DW-1:0]                alloc_v2,
  input  logic                         cdb_valid,
  input  logic [TAGW-1:0]              cdb_tag,
  input  logic [DW-1:0]                cdb_data,
  input  logic                         flush,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [3:0]                   issue_func,
  output logic [TAGW-1:0]              issue_rob,
  output logic [DW-1:0]                issue_v1,
  output logic [DW-1:0]                issue_v2,
  output logic [$clog2(ENTRIES+1)-1:0] count,
  output logic                         full
);
  import tomasulo_pkg::*;

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  rs_entry_t         ent [ENTRIES];
  logic [DW-1:0]     v1  [ENTRIES];
  logic [DW-1:0]     v2  [ENTRIES];
  logic [ENTRIES-1:0] ready_vec;
  logic [ENTRIES-1:0] grant;
  logic [IW-1:0]     sel_idx, last_idx, out_idx, alloc_idx;
  logic              sel_any, alloc_fire, issue_fire, cap1, cap2;
  rs_entry_t         new_ent;

  always_comb begin
    ready_vec = '0;
    count     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready_vec[i] = ent[i].busy && !ent[i].q1_busy && !ent[i].q2_busy;
      count        = count + CW'(ent[i].busy);
    end
  end

  assign full        = (count == CW'(ENTRIES));
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = issue_valid && issue_ready;

  // Lowest free slot, judged from start-of-cycle state so an issuing slot is not reused
  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!ent[i].busy && !found) begin
        found     = 1'b1;
        alloc_idx = IW'(i);
      end
    end
  end

  assign cap1 = alloc_q1_busy && cdb_valid && (alloc_q1_tag == cdb_tag);
  assign cap2 = alloc_q2_busy && cdb_valid && (alloc_q2_tag == cdb_tag);

  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.func    = alloc_func;
    new_ent.rob     = alloc_rob;
    new_ent.q1_busy = alloc_q1_busy && !cap1;
    new_ent.q1_tag  = alloc_q1_tag;
    new_ent.q2_busy = alloc_q2_busy && !cap2;
    new_ent.q2_tag  = alloc_q2_tag;
  end

`ifdef RS_AGE_PRIORITY_EN
  logic [ENTRIES*ENTRIES-1:0] older;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      older <= '0;
    end else if (flush) begin
      older <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (alloc_fire && (i == int'(alloc_idx)))
            older[i*ENTRIES+j] <= 1'b0;
          else if (alloc_fire && (j == int'(alloc_idx)))
            older[i*ENTRIES+j] <= ent[i].busy && !(issue_fire && (i == int'(sel_idx)));
          else if (issue_fire && (i == int'(sel_idx)))
            older[i*ENTRIES+j] <= 1'b0;
        end
      end
    end
  end
`endif

  rs_select #(.N(ENTRIES), .IW(IW)) u_select (
    .ready (ready_vec),
`ifdef RS_AGE_PRIORITY_EN
    .older (older),
`endif
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign out_idx     = sel_any ? sel_idx : last_idx;
  assign issue_valid = sel_any;
  assign issue_func  = ent[out_idx].func;
  assign issue_rob   = ent[out_idx].rob;
  assign issue_v1    = v1[out_idx];
  assign issue_v2    = v2[out_idx];

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      last_idx <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent[i] <= '0;
        v1[i]  <= '0;
        v2[i]  <= '0;
      end
    end else begin
      if (sel_any) last_idx <= sel_idx;
      for (int i = 0; i < ENTRIES; i++) begin
        if (cdb_valid && ent[i].busy) begin
          if (ent[i].q1_busy && (ent[i].q1_tag == cdb_tag)) begin
            ent[i].q1_busy <= 1'b0;
            v1[i]          <= cdb_data;
          end
          if (ent[i].q2_busy && (ent[i].q2_tag == cdb_tag)) begin
            ent[i].q2_busy <= 1'b0;
            v2[i]          <= cdb_data;
          end
        end
      end
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) ent[i].busy <= 1'b0;
      end else begin
        if (issue_fire) ent[sel_idx].busy <= 1'b0;
        if (alloc_fire) begin
          ent[alloc_idx] <= new_ent;
          v1[alloc_idx]  <= cap1 ? cdb_data : alloc_v1;
          v2[alloc_idx]  <= cap2 ? cdb_data : alloc_v2;
        end
      end
    end
  end

  logic unused_grant;
  assign unused_grant = ^grant;

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - scoreboard bench for rs_issue_sched (honours RS_AGE_PRIORITY_EN)
module tb_rs_issue_sched;
  import tomasulo_pkg::*;

  logic        clk2 = 1'b0;
  logic        rst_n;
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_func;
  logic [2:0]  alloc_rob, alloc_q1_tag, alloc_q2_tag;
  logic        alloc_q1_busy, alloc_q2_busy;
  logic [15:0] alloc_v1, alloc_v2;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        flush;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_func;
  logic [2:0]  issue_rob;
  logic [15:0] issue_v1, issue_v2;
  logic [2:0]  count;
  logic        full;

  typedef struct {
    logic [3:0]  func;
    logic [2:0]  rob;
    logic [15:0] v1;
    logic [15:0] v2;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk2 = ~clk2;

  rs_issue_sched #(.ENTRIES(4), .DW(16), .TAGW(3)) dut (
    .clk2(clk2), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_func(alloc_func),
    .alloc_rob(alloc_rob), .alloc_q1_busy(alloc_q1_busy), .alloc_q2_busy(alloc_q2_busy),
    .alloc_q1_tag(alloc_q1_tag), .alloc_q2_tag(alloc_q2_tag),
    .alloc_v1(alloc_v1), .alloc_v2(alloc_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
    .issue_rob(issue_rob), .issue_v1(issue_v1), .issue_v2(issue_v2),
    .count(count), .full(full)
  );

  task automatic clear_inputs();
    alloc_valid = 0; alloc_func = 0; alloc_rob = 0;
    alloc_q1_busy = 0; alloc_q2_busy = 0; alloc_q1_tag = 0; alloc_q2_tag = 0;
    alloc_v1 = 0; alloc_v2 = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    flush = 0; issue_ready = 0;
  endtask

  task automatic set_alloc(input logic [3:0] f, input logic [2:0] rob,
                           input logic b1, input logic [2:0] t1, input logic [15:0] a1,
                           input logic b2, input logic [2:0] t2, input logic [15:0] a2);
    alloc_valid = 1; alloc_func = f; alloc_rob = rob;
    alloc_q1_busy = b1; alloc_q1_tag = t1; alloc_v1 = a1;
    alloc_q2_busy = b2; alloc_q2_tag = t2; alloc_v2 = a2;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    @(negedge clk2);
    n_checks++;
    if ({count, full, alloc_ready, issue_valid} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_flags: got count=%0d full=%b ar=%b iv=%b want 0 0 1 0",
               count, full, alloc_ready, issue_valid);
    end
    n_checks++;
    if ({issue_func, issue_rob, issue_v1, issue_v2} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h/%h want all zero", issue_func, issue_rob, issue_v1, issue_v2);
    end
    rst_n = 1;
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk2);
      set_alloc(FN_ADD, 3'(k), 0, 0, 16'h0100 + 16'(k), 0, 0, 16'h0200 + 16'(k));
      sb.push_back('{FN_ADD, 3'(k), 16'h0100 + 16'(k), 16'h0200 + 16'(k)});
    end
    @(negedge clk2);
    alloc_valid = 0;
    n_checks++;
    if ({full, alloc_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b ar=%b count=%0d want 1 0 4", full, alloc_ready, count);
    end
    issue_ready = 1;
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      n_checks++;
      if ({issue_valid, issue_func, issue_rob, issue_v1, issue_v2} !== {1'b1, e.func, e.rob, e.v1, e.v2}) begin
        n_fail++;
        $display("FAIL drain_issue%0d: got iv=%b rob=%0d v1=%h v2=%h want 1 rob=%0d v1=%h v2=%h",
                 k, issue_valid, issue_rob, issue_v1, issue_v2, e.rob, e.v1, e.v2);
      end
      @(negedge clk2);
      n_checks++;
      if (count !== 3'(3 - k)) begin
        n_fail++;
        $display("FAIL drain_count%0d: got %0d want %0d", k, count, 3 - k);
      end
    end
    issue_ready = 0;
  endtask

  task automatic test_wakeup();
    @(negedge clk2);
    set_alloc(FN_MUL, 3'd4, 1, 3'd5, 16'hDEAD, 0, 0, 16'h0007);
    sb.push_back('{FN_MUL, 3'd4, 16'h1234, 16'h0007});
    @(negedge clk2);
    alloc_valid = 0;
    n_checks++;
    if ({issue_valid, count} !== {1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL wake_blocked: got iv=%b count=%0d want 0 1", issue_valid, count);
    end
    @(negedge clk2);
    cdb_valid = 1; cdb_tag = 3'd5; cdb_data = 16'h1234;
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_same_cycle: got iv=%b want 0", issue_valid);
    end
    @(negedge clk2);
    cdb_valid = 0;
    e = sb.pop_front();
    n_checks++;
    if ({issue_valid, issue_func, issue_rob, issue_v1, issue_v2} !== {1'b1, e.func, e.rob, e.v1, e.v2}) begin
      n_fail++;
      $display("FAIL wake_issue: got iv=%b f=%h rob=%0d v1=%h v2=%h want 1 f=%h rob=%0d v1=%h v2=%h",
               issue_valid, issue_func, issue_rob, issue_v1, issue_v2, e.func, e.rob, e.v1, e.v2);
    end
    issue_ready = 1;
    @(negedge clk2);
    issue_ready = 0;
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL wake_count: got %0d want 0", count);
    end
  endtask

  task automatic test_same_cycle_capture();
    @(negedge clk2);
    set_alloc(4'b1011, 3'd6, 0, 0, 16'h0A0A, 1, 3'd2, 16'hBEEF);
    cdb_valid = 1; cdb_tag = 3'd2; cdb_data = 16'h00FF;
    sb.push_back('{4'b1011, 3'd6, 16'h0A0A, 16'h00FF});
    @(negedge clk2);
    alloc_valid = 0; cdb_valid = 0;
    e = sb.pop_front();
    n_checks++;
    if ({issue_valid, issue_func, issue_rob, issue_v1, issue_v2} !== {1'b1, e.func, e.rob, e.v1, e.v2}) begin
      n_fail++;
      $display("FAIL capture_issue: got iv=%b f=%h rob=%0d v1=%h v2=%h want 1 f=%h rob=%0d v1=%h v2=%h",
               issue_valid, issue_func, issue_rob, issue_v1, issue_v2, e.func, e.rob, e.v1, e.v2);
    end
    issue_ready = 1;
    @(negedge clk2);
    issue_ready = 0;
  endtask

  task automatic test_priority();
    exp_t ea, eb;
    ea = '{FN_SUB, 3'd1, 16'h5555, 16'h0011};
    eb = '{FN_ADD, 3'd2, 16'h0022, 16'h0022};
    @(negedge clk2);
    set_alloc(FN_ADD, 3'd3, 0, 0, 16'h0003, 0, 0, 16'h0003);
    sb.push_back('{FN_ADD, 3'd3, 16'h0003, 16'h0003});
    @(negedge clk2);
    set_alloc(FN_SUB, 3'd1, 1, 3'd7, 16'h0000, 0, 0, 16'h0011);
    issue_ready = 1;
    e = sb.pop_front();
    n_checks++;
    if ({issue_valid, issue_rob, issue_v1} !== {1'b1, e.rob, e.v1}) begin
      n_fail++;
      $display("FAIL prio_first: got iv=%b rob=%0d v1=%h want 1 rob=%0d v1=%h",
               issue_valid, issue_rob, issue_v1, e.rob, e.v1);
    end
    @(negedge clk2);
    issue_ready = 0;
    n_checks++;
    if ({count, issue_valid} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_swap_count: got count=%0d iv=%b want 1 0", count, issue_valid);
    end
    set_alloc(FN_ADD, 3'd2, 0, 0, 16'h0022, 0, 0, 16'h0022);
`ifdef RS_AGE_PRIORITY_EN
    sb.push_back(ea); sb.push_back(eb);
`else
    sb.push_back(eb); sb.push_back(ea);
`endif
    @(negedge clk2);
    alloc_valid = 0;
    n_checks++;
    if ({issue_valid, issue_rob} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL prio_only_b: got iv=%b rob=%0d want 1 rob=2", issue_valid, issue_rob);
    end
    cdb_valid = 1; cdb_tag = 3'd7; cdb_data = 16'h5555;
    @(negedge clk2);
    cdb_valid = 0;
    issue_ready = 1;
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      n_checks++;
      if ({issue_valid, issue_func, issue_rob, issue_v1, issue_v2} !== {1'b1, e.func, e.rob, e.v1, e.v2}) begin
        n_fail++;
        $display("FAIL prio_order%0d: got iv=%b rob=%0d v1=%h v2=%h want 1 rob=%0d v1=%h v2=%h",
                 k, issue_valid, issue_rob, issue_v1, issue_v2, e.rob, e.v1, e.v2);
      end
      @(negedge clk2);
    end
    issue_ready = 0;
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL prio_count: got %0d want 0", count);
    end
  endtask

  task automatic test_full_alloc_issue();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk2);
      set_alloc(FN_LD, 3'(k), 0, 0, 16'h1000 + 16'(k), 0, 0, 16'(k));
      sb.push_back('{FN_LD, 3'(k), 16'h1000 + 16'(k), 16'(k)});
    end
    @(negedge clk2);
    set_alloc(FN_ST, 3'd4, 0, 0, 16'h4444, 0, 0, 16'h4444);
    issue_ready = 1;
    n_checks++;
    if ({count, alloc_ready} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL full_refuse: got count=%0d ar=%b want 4 0", count, alloc_ready);
    end
    e = sb.pop_front();
    n_checks++;
    if ({issue_valid, issue_rob, issue_v1} !== {1'b1, e.rob, e.v1}) begin
      n_fail++;
      $display("FAIL full_issue: got iv=%b rob=%0d v1=%h want 1 rob=%0d v1=%h",
               issue_valid, issue_rob, issue_v1, e.rob, e.v1);
    end
    @(negedge clk2);
    issue_ready = 0;
    n_checks++;
    if ({count, alloc_ready} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL full_freed: got count=%0d ar=%b want 3 1", count, alloc_ready);
    end
`ifdef RS_AGE_PRIORITY_EN
    sb.push_back('{FN_ST, 3'd4, 16'h4444, 16'h4444});
`else
    sb.push_front('{FN_ST, 3'd4, 16'h4444, 16'h4444});
`endif
    @(negedge clk2);
    alloc_valid = 0;
    n_checks++;
    if ({count, full} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL full_accept: got count=%0d full=%b want 4 1", count, full);
    end
    issue_ready = 1;
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      n_checks++;
      if ({issue_valid, issue_func, issue_rob, issue_v1, issue_v2} !== {1'b1, e.func, e.rob, e.v1, e.v2}) begin
        n_fail++;
        $display("FAIL full_drain%0d: got iv=%b f=%h rob=%0d v1=%h want 1 f=%h rob=%0d v1=%h",
                 k, issue_valid, issue_func, issue_rob, issue_v1, e.func, e.rob, e.v1);
      end
      @(negedge clk2);
    end
    issue_ready = 0;
  endtask

  task automatic test_flush_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk2);
      set_alloc(FN_BEQ, 3'(k), 0, 0, 16'h0700 + 16'(k), 0, 0, 16'h0000);
      sb.push_back('{FN_BEQ, 3'(k), 16'h0700 + 16'(k), 16'h0000});
    end
    @(negedge clk2);
    set_alloc(FN_BNE, 3'd5, 0, 0, 16'h0705, 0, 0, 16'h0000);
    issue_ready = 1;
    e = sb.pop_front();
    n_checks++;
    if ({count, issue_valid, issue_rob} !== {3'd3, 1'b1, e.rob}) begin
      n_fail++;
      $display("FAIL swap_pre: got count=%0d iv=%b rob=%0d want 3 1 rob=%0d", count, issue_valid, issue_rob, e.rob);
    end
    @(negedge clk2);
    alloc_valid = 0; issue_ready = 0;
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL swap_count: got %0d want 3", count);
    end
    flush = 1; issue_ready = 1;
    set_alloc(FN_ADD, 3'd6, 0, 0, 16'h0006, 0, 0, 16'h0006);
    n_checks++;
    if (issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_iv: got %b want 1", issue_valid);
    end
    @(negedge clk2);
    flush = 0; alloc_valid = 0; issue_ready = 0;
    sb.delete();
    n_checks++;
    if ({count, issue_valid} !== {3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_empty: got count=%0d iv=%b want 0 0", count, issue_valid);
    end
    for (int k = 0; k < 2; k++) begin
      set_alloc(FN_DIV, 3'd1 + 3'(k), 0, 0, 16'hABCD, 0, 0, 16'h1357);
      @(negedge clk2);
    end
    alloc_valid = 0;
    issue_ready = 1;
    n_checks++;
    if ({count, issue_valid} !== {3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset: got count=%0d iv=%b want 2 1", count, issue_valid);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({count, full, alloc_ready, issue_valid} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_flags: got count=%0d full=%b ar=%b iv=%b want 0 0 1 0",
               count, full, alloc_ready, issue_valid);
    end
    n_checks++;
    if ({issue_func, issue_rob, issue_v1, issue_v2} !== 39'd0) begin
      n_fail++;
      $display("FAIL async_reset_data: got %h/%h/%h/%h want all zero", issue_func, issue_rob, issue_v1, issue_v2);
    end
    @(negedge clk2);
    rst_n = 1;
    issue_ready = 0;
    @(negedge clk2);
    n_checks++;
    if ({count, issue_valid} !== {3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset: got count=%0d iv=%b want 0 0", count, issue_valid);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fill_drain();
    test_wakeup();
    test_same_cycle_capture();
    test_priority();
    test_full_alloc_issue();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
